ahb_sram_slave: RTL
===================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the 64-bit word address width of the internal array (4096 words, 32 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, meaning the byte base of the decoded window (8*2^ADDR_W bytes).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port hreset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port hsel  input  1  slave select.
REQ-006 SHALL have port haddr  input  64  address.
REQ-007 SHALL have port htrans  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 SHALL have port hwrite  input  1  write when 1.
REQ-009 SHALL have port hsize  input  3  transfer size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-010 SHALL have ports hburst  input  3, hprot  input  4, hmastlock  input  1; accepted and ignored.
REQ-011 SHALL have port hwdata  input  64  write data, valid in the data phase.
REQ-012 SHALL have port hready  input  1  bus-level ready, qualifies the address phase.
REQ-013 SHALL have port hreadyout  output  1  slave ready.
REQ-014 SHALL have port hresp  output  1  0=OKAY, 1=ERROR.
REQ-015 SHALL have port hrdata  output  64  read data, full 64-bit word.

Function
REQ-016 SHALL accept an address phase only when hsel & hready & htrans[1]; IDLE and BUSY transfers SHALL get a zero-wait OKAY and SHALL not access the array.
REQ-017 SHALL flag a transfer as error when any of these holds:
- haddr is outside the window;
- hsize > 3;
- haddr is misaligned to hsize.
REQ-018 SHALL use states S_IDLE, S_RD, S_WR, S_RDW, S_ERR1, S_ERR2; each state is the data-phase state of the previously accepted transfer.
REQ-019 SHALL drive S_ERR1 as hreadyout=0, hresp=1 and S_ERR2 as hreadyout=1, hresp=1, with no array access; S_ERR1 SHALL always go to S_ERR2.
REQ-020 SHALL issue a legal read to the synchronous array in its address-phase cycle, enter S_RD, and drive hrdata with the word at haddr[ADDR_W+2:3] in S_RD with hreadyout=1 (zero wait).
REQ-021 SHALL latch the address and size of a legal write, enter S_WR, and write hwdata into the array at the clock edge ending S_WR with hreadyout=1.
REQ-022 SHALL derive the byte-enable from haddr[2:0] and hsize: 1B -> 1 lane, 2B -> 2 lanes, 4B -> 4 lanes, 8B -> all 8 lanes.
REQ-023 SHALL give the array port to the write when a read address phase is accepted during S_WR, enter S_RDW (hreadyout=0, read issued from the latched address), then S_RD; read-after-write costs one wait state and SHALL return the just-written data.
REQ-024 SHALL resolve the next state from the new address phase accepted in any state with hreadyout=1 (S_IDLE, S_RD, S_WR, S_ERR2); a cycle with no accepted phase SHALL lead to S_IDLE.
REQ-025 SHALL drive hrdata to 64'h0 outside S_RD; in S_IDLE, S_WR and S_RD, hresp SHALL be 0.
REQ-026 SHALL not register any address phase during S_RDW or S_ERR1, per AHB.
REQ-027 SHALL handle back-to-back SEQ beats of any burst at one beat per cycle, except for the REQ-023 stall.

Reset
REQ-028 SHALL, on hreset_n low at any time including mid-transfer, enter S_IDLE with hreadyout=1, hresp=0, hrdata=0, and clear all latched address and size state.
REQ-029 SHALL leave array contents unchanged on reset; a write whose S_WR cycle is cut by reset SHALL not be committed.

Structure
REQ-030 SHALL place the HTRANS/HSIZE encodings and the state encoding in the shared package ahb_pkg.
REQ-031 SHALL instantiate one sub-module sp_sram_64: single-port, synchronous read, 64-bit, 8 byte-enables, depth 2^ADDR_W.

Verification
REQ-032 SHALL cover: 8B write 64'h1122334455667788 to BASE+0x10, then read at BASE+0x10 -> one wait state (S_RDW), hrdata=64'h1122334455667788, hresp=0.
REQ-033 SHALL cover: 1B write 8'hAA to BASE+0x13 over an array word of all zeros -> later 8B read at BASE+0x10 returns 64'h00000000AA000000.
REQ-034 SHALL cover: 4-beat INCR 8B read from BASE+0x0 of values 0,1,2,3 -> four consecutive hreadyout=1 cycles returning 0,1,2,3.
REQ-035 SHALL cover: read at BASE+0x2 with hsize=2 -> hreadyout,hresp = 0,1 then 1,1; the array is untouched and a following legal read returns OKAY.
REQ-036 SHALL cover: hreset_n pulsed low during S_WR of a write of 64'hFFFF to BASE+0x20 -> outputs reset immediately, and BASE+0x20 keeps its old value.
REQ-037 SHALL cover: htrans=BUSY inside a burst, and hsel=0 with htrans=NONSEQ -> zero-wait OKAY with no array access.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave state encoding and lane/alignment helpers
// for the 64-bit AHB SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_1B = 3'd0;
    localparam logic [2:0] HSIZE_2B = 3'd1;
    localparam logic [2:0] HSIZE_4B = 3'd2;
    localparam logic [2:0] HSIZE_8B = 3'd3;

    // Each state names the data phase of the previously accepted transfer.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RDW  = 3'd3,
        S_ERR1 = 3'd4,
        S_ERR2 = 3'd5
    } state_e;

    function automatic logic [7:0] byte_enable(input logic [2:0] offset,
                                               input logic [2:0] size);
        case (size)
            HSIZE_1B: byte_enable = 8'h01 << offset;
            HSIZE_2B: byte_enable = 8'h03 << offset;
            HSIZE_4B: byte_enable = 8'h0F << offset;
            default:  byte_enable = 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] offset,
                                        input logic [2:0] size);
        case (size)
            HSIZE_1B: misaligned = 1'b0;
            HSIZE_2B: misaligned = offset[0];
            HSIZE_4B: misaligned = |offset[1:0];
            HSIZE_8B: misaligned = |offset;
            default:  misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sp_sram_64.sv
// Single-port 64-bit SRAM with per-byte write enables and registered read.
// One byte-wide array per lane so each lane maps onto its own block RAM slice.
module sp_sram_64 #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [7:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic [63:0]       rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (en_i && we_i && be_i[gi]) begin
                    mem[addr_i] <= wdata_i[gi*8 +: 8];
                end
                if (en_i && !we_i) begin
                    rd_q <= mem[addr_i];
                end
            end

            assign rdata_o[gi*8 +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a 64-bit single-port SRAM: zero-wait reads and
// writes, one wait state for read-after-write, two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        hreset_n,
    input  logic        hsel,
    input  logic [63:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [63:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [63:0] hrdata
);

    localparam logic [63:0] WIN_BYTES = 64'd8 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W+2:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              ready_q;
    logic              resp_q;

    logic              accept;
    logic              in_window;
    logic              bad;
    logic              rd_now;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_rdata;

    logic              unused_ok;
    assign unused_ok = ^{htrans[0], hburst, hprot, hmastlock};

    // No new address phase is taken while this slave is stalling the bus.
    assign accept    = hsel & hready & htrans[1] & ready_q;
    assign in_window = (haddr >= BASE_ADDR) && ((haddr - BASE_ADDR) < WIN_BYTES);
    assign bad       = !in_window || (hsize > HSIZE_8B) || misaligned(haddr[2:0], hsize);
    assign rd_now    = accept && !bad && !hwrite && (state_q != S_WR);

    always_comb begin
        state_d = S_IDLE;
        addr_d  = addr_q;
        size_d  = size_q;
        case (state_q)
            S_RDW:   state_d = S_RD;
            S_ERR1:  state_d = S_ERR2;
            default: begin
                if (accept) begin
                    if (bad) begin
                        state_d = S_ERR1;
                    end else begin
                        addr_d = haddr[ADDR_W+2:0];
                        size_d = hsize;
                        if (hwrite) begin
                            state_d = S_WR;
                        end else if (state_q == S_WR) begin
                            state_d = S_RDW;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            ready_q <= !(state_d inside {S_RDW, S_ERR1});
            resp_q  <= (state_d inside {S_ERR1, S_ERR2});
        end
    end

    // The pending write owns the port in S_WR; a deferred read uses it in S_RDW.
    assign ram_we   = (state_q == S_WR);
    assign ram_en   = ram_we || rd_now || (state_q == S_RDW);
    assign ram_addr = (ram_we || (state_q == S_RDW)) ? addr_q[ADDR_W+2:3]
                                                     : haddr[ADDR_W+2:3];

    sp_sram_64 #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (byte_enable(addr_q[2:0], size_q)),
        .addr_i  (ram_addr),
        .wdata_i (hwdata),
        .rdata_o (ram_rdata)
    );

    assign hreadyout = ready_q;
    assign hresp     = resp_q;
    assign hrdata    = (state_q == S_RD) ? ram_rdata : 64'h0;

endmodule
